// File: rtl/cp0_defs.sv
// CP0 register numbers, exception codes and Status/Cause field positions
// shared by the CP0 register file and its timer.
package cp0_defs;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;
  localparam logic [4:0] CP0_PRID     = 5'd15;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_BP   = 5'd9,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  localparam int ST_IE    = 0;
  localparam int ST_EXL   = 1;
  localparam int IM_LO    = 8;
  localparam int IM_HI    = 15;
  localparam int CA_BD    = 31;
  localparam int IP_LO    = 8;
  localparam int IP_HI    = 15;
  localparam int EXC_LO   = 2;
  localparam int EXC_HI   = 6;

  // BEV is hardwired to 1; only IM, EXL and IE are software-writable.
  localparam logic [31:0] CP0_STATUS_RST = 32'h0040_0000;
  localparam logic [31:0] STATUS_BEV     = 32'h0040_0000;
  localparam logic [31:0] STATUS_WMASK   = 32'h0000_FF03;

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: Count advances once every two clocks and a
// Count==Compare match raises a sticky flag cleared by writing Compare.
module cp0_timer
  import cp0_defs::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        timer_int
);

  logic tick;
  logic wr_count;
  logic wr_compare;

  assign wr_count   = we && (waddr == CP0_COUNT);
  assign wr_compare = we && (waddr == CP0_COMPARE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tick      <= 1'b0;
      count     <= 32'd0;
      compare   <= 32'd0;
      timer_int <= 1'b0;
    end else begin
      tick <= ~tick;
      if (wr_count)
        count <= wdata;
      else if (tick)
        count <= count + 32'd1;
      if (wr_compare)
        compare <= wdata;
      // A Compare write acknowledges the interrupt and beats a same-cycle match.
      if (wr_compare)
        timer_int <= 1'b0;
      else if ((count == compare) && (compare != 32'd0))
        timer_int <= 1'b1;
    end
  end

endmodule

// File: rtl/cp0_regfile.sv
// CP0 system-control register file: MTC0/MFC0 access, exception and ERET
// commit, interrupt pending generation and the Count/Compare timer.
module cp0_regfile
  import cp0_defs::*;
#(
  parameter logic [31:0] PRID_VAL   = 32'h0000_4220,
  parameter logic [31:0] STATUS_RST = CP0_STATUS_RST
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_i,
  output logic [31:0] rdata_o,
  input  logic [5:0]  int_i,
  input  logic        exc_valid_i,
  input  logic [4:0]  exc_code_i,
  input  logic [31:0] exc_pc_i,
  input  logic        exc_bd_i,
  input  logic [31:0] exc_badvaddr_i,
  input  logic        eret_i,
  output logic [31:0] epc_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic        int_pending_o,
  output logic        timer_int_o
);

  logic [31:0] status_q;
  logic [31:0] cause_q;
  logic [31:0] epc_q;
  logic [31:0] badvaddr_q;
  logic [31:0] count;
  logic [31:0] compare;
  logic        timer_int;
  logic        wr_status;
  logic        wr_cause;
  logic        wr_epc;
  logic        exl;

  assign wr_status = we_i && (waddr_i == CP0_STATUS);
  assign wr_cause  = we_i && (waddr_i == CP0_CAUSE);
  assign wr_epc    = we_i && (waddr_i == CP0_EPC);
  assign exl       = status_q[ST_EXL];

  cp0_timer u_timer (
    .clk       (clk),
    .resetn    (resetn),
    .we        (we_i),
    .waddr     (waddr_i),
    .wdata     (wdata_i),
    .count     (count),
    .compare   (compare),
    .timer_int (timer_int)
  );

  // Exception beats ERET beats MTC0 on the Status/Cause/EPC fields.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      status_q <= STATUS_RST;
    else if (exc_valid_i)
      status_q[ST_EXL] <= 1'b1;
    else if (eret_i)
      status_q[ST_EXL] <= 1'b0;
    else if (wr_status)
      status_q <= (wdata_i & STATUS_WMASK) | STATUS_BEV;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cause_q <= 32'd0;
    end else begin
      cause_q[IP_HI:10] <= {int_i[5] | timer_int, int_i[4:0]};
      if (exc_valid_i) begin
        cause_q[EXC_HI:EXC_LO] <= exc_code_i;
        if (!exl)
          cause_q[CA_BD] <= exc_bd_i;
      end else if (!eret_i && wr_cause) begin
        cause_q[9:IP_LO] <= wdata_i[9:8];
      end
    end
  end

  // Nested exceptions (EXL already set) keep the original return address.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      epc_q <= 32'd0;
    else if (exc_valid_i) begin
      if (!exl)
        epc_q <= exc_bd_i ? (exc_pc_i - 32'd4) : exc_pc_i;
    end else if (!eret_i && wr_epc)
      epc_q <= wdata_i;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      badvaddr_q <= 32'd0;
    else if (exc_valid_i && ((exc_code_i == EXC_ADEL) || (exc_code_i == EXC_ADES)))
      badvaddr_q <= exc_badvaddr_i;
  end

  always_comb begin
    rdata_o = 32'd0;
    case (raddr_i)
      CP0_BADVADDR: rdata_o = badvaddr_q;
      CP0_COUNT:    rdata_o = count;
      CP0_COMPARE:  rdata_o = compare;
      CP0_STATUS:   rdata_o = status_q;
      CP0_CAUSE:    rdata_o = cause_q;
      CP0_EPC:      rdata_o = epc_q;
      CP0_PRID:     rdata_o = PRID_VAL;
      default:      rdata_o = 32'd0;
    endcase
  end

  assign epc_o         = epc_q;
  assign status_o      = status_q;
  assign cause_o       = cause_q;
  assign timer_int_o   = timer_int;
  assign int_pending_o = status_q[ST_IE] & ~exl &
                         (|(cause_q[IP_HI:IP_LO] & status_q[IM_HI:IM_LO]));

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed scoreboard bench for cp0_regfile: stimulus queues expected values,
// a negedge monitor pops and compares them against the selected DUT output.
module tb_cp0_regfile;

  localparam int SEL_RDATA = 0;
  localparam int SEL_TIMER = 1;
  localparam int SEL_PEND  = 2;
  localparam int SEL_EPC   = 3;
  localparam int SEL_STAT  = 4;
  localparam int SEL_CAUSE = 5;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] mask;
    logic [31:0] exp;
  } exp_t;

  logic        clk;
  logic        resetn;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
  logic [4:0]  raddr_i;
  logic [31:0] rdata_o;
  logic [5:0]  int_i;
  logic        exc_valid_i;
  logic [4:0]  exc_code_i;
  logic [31:0] exc_pc_i;
  logic        exc_bd_i;
  logic [31:0] exc_badvaddr_i;
  logic        eret_i;
  logic [31:0] epc_o;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic        int_pending_o;
  logic        timer_int_o;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [31:0] mon_got;
  logic        chk_req;
  int          n_cmp;
  int          n_fail;

  cp0_regfile dut (
    .clk            (clk),
    .resetn         (resetn),
    .we_i           (we_i),
    .waddr_i        (waddr_i),
    .wdata_i        (wdata_i),
    .raddr_i        (raddr_i),
    .rdata_o        (rdata_o),
    .int_i          (int_i),
    .exc_valid_i    (exc_valid_i),
    .exc_code_i     (exc_code_i),
    .exc_pc_i       (exc_pc_i),
    .exc_bd_i       (exc_bd_i),
    .exc_badvaddr_i (exc_badvaddr_i),
    .eret_i         (eret_i),
    .epc_o          (epc_o),
    .status_o       (status_o),
    .cause_o        (cause_o),
    .int_pending_o  (int_pending_o),
    .timer_int_o    (timer_int_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: pops one expectation per requested sample.
  always @(negedge clk) begin
    if (chk_req) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL scoreboard_underflow: sample requested with no expectation queued");
      end else begin
        mon_e = sb_q.pop_front();
        case (mon_e.sel)
          SEL_RDATA: mon_got = rdata_o;
          SEL_TIMER: mon_got = {31'd0, timer_int_o};
          SEL_PEND:  mon_got = {31'd0, int_pending_o};
          SEL_EPC:   mon_got = epc_o;
          SEL_STAT:  mon_got = status_o;
          default:   mon_got = cause_o;
        endcase
        n_cmp++;
        if ((mon_got & mon_e.mask) !== (mon_e.exp & mon_e.mask)) begin
          n_fail++;
          $display("FAIL %s: got=%08h expected=%08h (mask %08h)",
                   mon_e.name, mon_got & mon_e.mask, mon_e.exp & mon_e.mask, mon_e.mask);
        end
      end
    end
  end

  task automatic check(input string name, input int sel, input logic [4:0] addr,
                       input logic [31:0] mask, input logic [31:0] exp);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.mask = mask;
    e.exp  = exp;
    raddr_i = addr;
    sb_q.push_back(e);
    chk_req = 1'b1;
    @(negedge clk);
    #1 chk_req = 1'b0;
  endtask

  task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
    we_i    = 1'b1;
    waddr_i = addr;
    wdata_i = data;
    @(posedge clk);
    #1 we_i = 1'b0;
  endtask

  task automatic exc_pulse(input logic [4:0] code, input logic [31:0] pc,
                           input logic bd, input logic [31:0] bva);
    exc_valid_i    = 1'b1;
    exc_code_i     = code;
    exc_pc_i       = pc;
    exc_bd_i       = bd;
    exc_badvaddr_i = bva;
    @(posedge clk);
    #1 exc_valid_i = 1'b0;
  endtask

  task automatic eret_pulse();
    eret_i = 1'b1;
    @(posedge clk);
    #1 eret_i = 1'b0;
  endtask

  initial begin
    bit found;
    n_cmp          = 0;
    n_fail         = 0;
    chk_req        = 1'b0;
    resetn         = 1'b0;
    we_i           = 1'b0;
    waddr_i        = 5'd0;
    wdata_i        = 32'd0;
    raddr_i        = 5'd0;
    int_i          = 6'd0;
    exc_valid_i    = 1'b0;
    exc_code_i     = 5'd0;
    exc_pc_i       = 32'd0;
    exc_bd_i       = 1'b0;
    exc_badvaddr_i = 32'd0;
    eret_i         = 1'b0;

    // Reset state, sampled while reset is held
    check("rst_status", SEL_RDATA, 5'd12, 32'hFFFF_FFFF, 32'h0040_0000);
    check("rst_cause",  SEL_RDATA, 5'd13, 32'hFFFF_FFFF, 32'h0000_0000);
    check("rst_count",  SEL_RDATA, 5'd9,  32'hFFFF_FFFF, 32'h0000_0000);
    check("rst_timer",  SEL_TIMER, 5'd0,  32'h1,         32'h0);

    @(posedge clk);
    #1 resetn = 1'b1;
    repeat (10) @(posedge clk);
    check("count_after_10", SEL_RDATA, 5'd9, 32'hFFFF_FFFF, 32'd5);

    // Timer interrupt
    mtc0(5'd11, 32'd8);
    mtc0(5'd9, 32'd0);
    raddr_i = 5'd9;
    found = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk);
      #1;
      if (rdata_o == 32'd8) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      n_cmp++;
      n_fail++;
      $display("FAIL count_reach_8: Count never read 8 within 64 cycles");
    end
    check("timer_pre",   SEL_TIMER, 5'd0,  32'h1,         32'h0);
    check("timer_set",   SEL_TIMER, 5'd0,  32'h1,         32'h1);
    check("cause_ip7",   SEL_RDATA, 5'd13, 32'h0000_8000, 32'h0000_8000);
    mtc0(5'd12, 32'h0000_8001);
    check("status_wr",   SEL_RDATA, 5'd12, 32'hFFFF_FFFF, 32'h0040_8001);
    check("pend_timer",  SEL_PEND,  5'd0,  32'h1,         32'h1);
    mtc0(5'd11, 32'h0000_0020);
    check("timer_clr",   SEL_TIMER, 5'd0,  32'h1,         32'h0);
    mtc0(5'd11, 32'h8000_0000);

    // Exceptions, EPC, BD, nested EXL
    exc_pulse(5'd10, 32'hBFC0_0100, 1'b1, 32'd0);
    check("exc_epc_bd",  SEL_EPC,   5'd0,  32'hFFFF_FFFF, 32'hBFC0_00FC);
    check("exc_cause",   SEL_CAUSE, 5'd0,  32'h8000_007C, 32'h8000_0028);
    check("exc_exl",     SEL_RDATA, 5'd12, 32'h0000_0002, 32'h0000_0002);
    exc_pulse(5'd8, 32'h0000_0200, 1'b0, 32'd0);
    check("nest_epc",    SEL_EPC,   5'd0,  32'hFFFF_FFFF, 32'hBFC0_00FC);
    check("nest_cause",  SEL_CAUSE, 5'd0,  32'h8000_007C, 32'h8000_0020);

    // BadVAddr capture only on address errors
    exc_pulse(5'd4, 32'h0000_0400, 1'b0, 32'h0000_0003);
    check("badva_adel",  SEL_RDATA, 5'd8,  32'hFFFF_FFFF, 32'h0000_0003);
    exc_pulse(5'd12, 32'h0000_0404, 1'b0, 32'h0000_1234);
    check("badva_keep",  SEL_RDATA, 5'd8,  32'hFFFF_FFFF, 32'h0000_0003);
    check("code_ov",     SEL_CAUSE, 5'd0,  32'h0000_007C, 32'h0000_0030);

    // ERET, then exception + ERET + MTC0 Status in one cycle
    eret_pulse();
    check("eret_exl",    SEL_STAT,  5'd0,  32'hFFFF_FFFF, 32'h0040_8001);
    exc_valid_i    = 1'b1;
    exc_code_i     = 5'd8;
    exc_pc_i       = 32'h0000_0300;
    exc_bd_i       = 1'b0;
    eret_i         = 1'b1;
    we_i           = 1'b1;
    waddr_i        = 5'd12;
    wdata_i        = 32'd0;
    @(posedge clk);
    #1;
    exc_valid_i = 1'b0;
    eret_i      = 1'b0;
    we_i        = 1'b0;
    check("prio_status", SEL_STAT,  5'd0,  32'hFFFF_FFFF, 32'h0040_8003);
    check("prio_epc",    SEL_EPC,   5'd0,  32'hFFFF_FFFF, 32'h0000_0300);
    eret_pulse();
    check("eret2_exl",   SEL_STAT,  5'd0,  32'hFFFF_FFFF, 32'h0040_8001);

    // Cause write mask, hardware interrupt, unmapped / read-only registers
    mtc0(5'd13, 32'hFFFF_FFFF);
    check("cause_wmask", SEL_CAUSE, 5'd0,  32'h0000_FF00, 32'h0000_0300);
    mtc0(5'd12, 32'h0000_0401);
    check("status_im10", SEL_RDATA, 5'd12, 32'hFFFF_FFFF, 32'h0040_0401);
    check("pend_none",   SEL_PEND,  5'd0,  32'h1,         32'h0);
    int_i = 6'b000001;
    check("pend_hw0",    SEL_PEND,  5'd0,  32'h1,         32'h1);
    int_i = 6'b000000;
    check("read_unmap",  SEL_RDATA, 5'd7,  32'hFFFF_FFFF, 32'h0000_0000);
    check("read_prid",   SEL_RDATA, 5'd15, 32'hFFFF_FFFF, 32'h0000_4220);
    mtc0(5'd8, 32'hDEAD_BEEF);
    check("badva_ro",    SEL_RDATA, 5'd8,  32'hFFFF_FFFF, 32'h0000_0003);

    // Count wrap
    mtc0(5'd9, 32'hFFFF_FFFF);
    repeat (2) @(posedge clk);
    check("count_wrap",  SEL_RDATA, 5'd9,  32'hFFFF_FFFF, 32'h0000_0000);

    // Asynchronous reset mid-operation
    resetn = 1'b0;
    check("mid_rst_stat", SEL_STAT,  5'd0, 32'hFFFF_FFFF, 32'h0040_0000);
    check("mid_rst_epc",  SEL_EPC,   5'd0, 32'hFFFF_FFFF, 32'h0000_0000);
    check("mid_rst_badva",SEL_RDATA, 5'd8, 32'hFFFF_FFFF, 32'h0000_0000);
    resetn = 1'b1;

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left, 0 required", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
